silly_sweep_ctrl: RTL and testbench
===================================

// Module: silly_sweep_ctrl
// PURPOSE
//  Sequencer for the 3-input combinational lab block (a,b,c -> y).
//  On start: drives all 8 input combinations in binary order, then N_RAND
//  pseudo-random vectors. Samples y after a programmable settle time and
//  compares it against a parameterised truth table. Reports busy/done,
//  pass/fail, the error count and the first failing vector index.
// PARAMETERS
//  EXPECTED  8'hE8  expected truth table; y must equal EXPECTED[{a,b,c}]
//  SETTLE    1      cycles a vector is held before its sample cycle (>=1)
//  N_RAND    3      number of random vectors after the exhaustive sweep (>=0)
//  SEED      8'h5A  LFSR seed; a value of 0 is replaced by 8'h01
//  derived: TOTAL=8+N_RAND, CW=$clog2(TOTAL+1), IW=$clog2(TOTAL)
// PORTS
//  clk             in   1   system clock, rising edge
//  reset_b         in   1   asynchronous active-low reset
//  start           in   1   level; sampled in IDLE or DONE
//  a               out  1   DUT input, MSB of vector
//  b               out  1   DUT input
//  c               out  1   DUT input, LSB of vector
//  y               in   1   DUT output under check
//  busy            out  1   high from the start edge until the last sample
//  done            out  1   level; high in DONE until the next start
//  pass            out  1   done && err_count==0
//  err_count       out  CW  mismatches in this run; saturates at all-ones
//  first_fail_idx  out  IW  index (0..TOTAL-1) of the first mismatching vector
// BEHAVIOUR
//  Reset (asynchronous, at any time including mid-run): state IDLE; a,b,c,
//   busy, done, pass, err_count and first_fail_idx all 0; LFSR <= SEED.
//  FSM: IDLE -> HOLD -> SAMPLE -> (HOLD | DONE); DONE -> HOLD on start.
//  IDLE/DONE with start=1 at edge t0: idx<=0, {a,b,c}<=3'b000, err_count<=0,
//   first_fail_idx<=0, LFSR<=SEED, busy<=1, done<=0, go to HOLD.
//  HOLD: vector stable for SETTLE cycles (internal settle counter), then SAMPLE.
//  SAMPLE (1 cycle): compare y with EXPECTED[{a,b,c}] as registered at the
//   closing edge. On mismatch: err_count+1 (saturating); if this is the first
//   error, first_fail_idx<=idx. Then at the same edge:
//   - if idx==TOTAL-1: busy<=0, done<=1, {a,b,c} held, go to DONE;
//   - else idx+1 and load the next vector, go to HOLD.
//  Vector order: idx 0..7 -> {a,b,c}=idx[2:0]; idx 8+j -> LFSR[2:0], then
//   LFSR advances one step (x^8+x^6+x^5+x^4+1, Fibonacci, shift left,
//   feedback into bit 0). The first random vector is SEED[2:0].
//  Latency: done rises (SETTLE+1)*TOTAL cycles after the t0 edge.
//  start while busy (HOLD/SAMPLE) is ignored; no abort.
//  start held high in DONE restarts the run on the next edge.
//  All outputs are registered; no combinational path from y or start to any output.
//  pass is 0 whenever done=0.
// TESTING
//  1 Reference model y=EXPECTED[abc], SETTLE=1, N_RAND=3, start pulse at t0
//    -> a,b,c = 000,001,...,111,010,... each held 2 cycles; done=1 and pass=1
//    exactly at t0+22; err_count=0; busy=1 on t0..t0+21 only.
//  2 y tied to 0, EXPECTED=8'hE8 -> first_fail_idx=3; err_count =
//    4 + (number of random vectors whose EXPECTED bit is 1, from the model);
//    pass=0.
//  3 SETTLE=3 -> each vector held 4 cycles; done at t0+44; the sample uses y
//    from the 4th cycle only (glitch y on cycles 1-3: no error counted).
//  4 Pulse start again at t0+5 -> ignored: the vector sequence and done time are
//    unchanged. Assert reset_b=0 at t0+9 -> all outputs 0 asynchronously,
//    IDLE; a new start then begins again at 000.
//  5 After test 2 finishes, start with the reference model -> err_count and
//    first_fail_idx cleared at the start edge; pass=1 at the end.
//  6 SEED=0, N_RAND=1 -> the random vector is 3'b001 (seed replaced by 8'h01);
//    done at t0+18.

Source files
------------

// File: rtl/silly_sweep_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | silly_sweep_ctrl: exhaustive + LFSR vector sweep checker for a 3-in block |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module silly_sweep_ctrl #(
  parameter logic [7:0] EXPECTED = 8'hE8,
  parameter int         SETTLE   = 1,
  parameter int         N_RAND   = 3,
  parameter logic [7:0] SEED     = 8'h5A,
  localparam int        TOTAL    = 8 + N_RAND,
  localparam int        CW       = $clog2(TOTAL + 1),
  localparam int        IW       = $clog2(TOTAL)
) (
  input  logic          clk,
  input  logic          reset_b,
  input  logic          start,
  output logic          a,
  output logic          b,
  output logic          c,
  input  logic          y,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] err_count,
  output logic [IW-1:0] first_fail_idx
);

  localparam int         SW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [SW-1:0]   settle_cnt;
  logic [7:0]      lfsr;

  logic            mismatch;
  logic [CW-1:0]   err_next;
  logic            last_vec;
  logic [7:0]      lfsr_next;
  logic [2:0]      next_vec;

  always_comb begin
    mismatch  = (y != EXPECTED[{a, b, c}]);
    err_next  = err_count;
    if (mismatch && (err_count != {CW{1'b1}}))
      err_next = err_count + CW'(1);
    last_vec  = (idx == IW'(TOTAL - 1));
    lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    // idx 0..6 step through the binary sweep; from idx 7 on the LFSR feeds vectors
    next_vec  = (idx < IW'(7)) ? (idx[2:0] + 3'd1) : lfsr[2:0];
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state          <= S_IDLE;
      idx            <= '0;
      settle_cnt     <= '0;
      lfsr           <= SEED_EFF;
      {a, b, c}      <= 3'b000;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_fail_idx <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            idx            <= '0;
            settle_cnt     <= '0;
            lfsr           <= SEED_EFF;
            {a, b, c}      <= 3'b000;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_fail_idx <= '0;
            state          <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (settle_cnt == SW'(SETTLE - 1)) begin
            settle_cnt <= '0;
            state      <= S_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        S_SAMPLE: begin
          err_count <= err_next;
          if (mismatch && (err_count == '0))
            first_fail_idx <= idx;
          if (last_vec) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
            state <= S_DONE;
          end else begin
            idx       <= idx + IW'(1);
            {a, b, c} <= next_vec;
            if (idx >= IW'(7))
              lfsr <= lfsr_next;
            state <= S_HOLD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_silly_sweep_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_silly_sweep_ctrl: scoreboard bench for silly_sweep_ctrl (3 configs)    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_silly_sweep_ctrl;

  logic       clk = 1'b0;
  logic       reset_b = 1'b0;
  logic [2:0] start = 3'b000;
  logic [2:0] a, b, c, busy, done, pass;
  logic [3:0] err [3];
  logic [3:0] ffi [3];
  logic       y0, y1, y2;
  logic       y0_zero = 1'b0;
  logic [7:0] exp_tt = 8'hE8;

  int cyc = 0;
  int t0 [3] = '{0, 0, 0};
  int starts [3] = '{0, 0, 0};
  int aborts [3] = '{0, 0, 0};
  int dones [3] = '{0, 0, 0};
  int seen_ab [3] = '{0, 0, 0};
  int checks = 0;
  int fails = 0;

  typedef struct {
    int dut;
    int lat;
    int err;
    int ffi;
    int pass;
  } res_t;

  res_t       q_res[$];
  logic [2:0] q_vec[$];
  res_t       mon_r;
  int         mon_k;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference lab block; dut1 sees y inverted on every non-sample cycle of a 4-cycle hold
  assign y0 = y0_zero ? 1'b0 : exp_tt[{a[0], b[0], c[0]}];
  assign y1 = exp_tt[{a[1], b[1], c[1]}] ^
              ((starts[1] != dones[1] + aborts[1]) && (((cyc - t0[1]) % 4) != 3));
  assign y2 = exp_tt[{a[2], b[2], c[2]}];

  silly_sweep_ctrl dut0 (
    .clk(clk), .reset_b(reset_b), .start(start[0]),
    .a(a[0]), .b(b[0]), .c(c[0]), .y(y0),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_count(err[0]), .first_fail_idx(ffi[0])
  );

  silly_sweep_ctrl #(.SETTLE(3)) dut1 (
    .clk(clk), .reset_b(reset_b), .start(start[1]),
    .a(a[1]), .b(b[1]), .c(c[1]), .y(y1),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_count(err[1]), .first_fail_idx(ffi[1])
  );

  silly_sweep_ctrl #(.SEED(8'h00), .N_RAND(1)) dut2 (
    .clk(clk), .reset_b(reset_b), .start(start[2]),
    .a(a[2]), .b(b[2]), .c(c[2]), .y(y2),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]),
    .err_count(err[2]), .first_fail_idx(ffi[2])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: actual %0d, required %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic int sett(input int d);
    return (d == 1) ? 3 : 1;
  endfunction

  // Monitor: per-vector check at the first cycle of each hold, result check on done
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (aborts[d] != seen_ab[d]) begin
        seen_ab[d] = aborts[d];
        q_vec.delete();
      end else if (starts[d] != dones[d] + aborts[d]) begin
        mon_k = cyc - t0[d];
        if (done[d]) begin
          if (q_res.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_done: dut %0d raised done with no expected result", d);
          end else begin
            mon_r = q_res.pop_front();
            chk("done_dut", 32'(d), 32'(mon_r.dut));
            chk("done_latency", 32'(mon_k), 32'(mon_r.lat));
            chk("err_count", 32'(err[d]), 32'(mon_r.err));
            chk("first_fail_idx", 32'(ffi[d]), 32'(mon_r.ffi));
            chk("pass", 32'(pass[d]), 32'(mon_r.pass));
            chk("busy_at_done", 32'(busy[d]), 32'd0);
          end
          dones[d] = dones[d] + 1;
        end else begin
          chk("busy_in_run", 32'(busy[d]), 32'd1);
          chk("pass_low_in_run", 32'(pass[d]), 32'd0);
          if ((mon_k % (sett(d) + 1)) == 0) begin
            if (q_vec.size() == 0) begin
              checks++;
              fails++;
              $display("FAIL extra_vector: dut %0d at cycle %0d, none expected", d, mon_k);
            end else begin
              chk("vector", 32'({a[d], b[d], c[d]}), 32'(q_vec.pop_front()));
            end
          end
        end
      end
    end
  end

  task automatic push_sweep();
    for (int i = 0; i < 8; i++) q_vec.push_back(3'(i));
  endtask

  task automatic push_rand_5a();
    q_vec.push_back(3'b010);
    q_vec.push_back(3'b100);
    q_vec.push_back(3'b001);
  endtask

  task automatic push_res(input int d, input int lat, input int e, input int f, input int p);
    res_t r;
    r.dut = d; r.lat = lat; r.err = e; r.ffi = f; r.pass = p;
    q_res.push_back(r);
  endtask

  task automatic kick(input int d);
    @(negedge clk);
    start[d] = 1'b1;
    @(posedge clk);
    #1;
    t0[d] = cyc;
    starts[d]++;
    start[d] = 1'b0;
  endtask

  task automatic wait_run(input int d, input int budget);
    int i;
    i = 0;
    while ((starts[d] != dones[d] + aborts[d]) && (i < budget)) begin
      @(posedge clk);
      i++;
    end
    if (starts[d] != dones[d] + aborts[d]) begin
      checks++;
      fails++;
      $display("FAIL run_timeout: dut %0d not done after %0d cycles", d, budget);
    end
    @(negedge clk);
  endtask

  task automatic chk_zero(input string nm, input int d);
    chk(nm, 32'({a[d], b[d], c[d], busy[d], done[d], pass[d], err[d], ffi[d]}), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    for (int d = 0; d < 3; d++) chk_zero("reset_outputs", d);
    @(negedge clk);
    reset_b = 1'b1;

    // Reference model, default parameters
    push_sweep(); push_rand_5a(); push_res(0, 22, 0, 0, 1);
    kick(0); wait_run(0, 100);

    // y stuck at 0: errors at idx 3,5,6,7; random vectors 2,4,1 all expect 0
    y0_zero = 1'b1;
    push_sweep(); push_rand_5a(); push_res(0, 22, 4, 3, 0);
    kick(0); wait_run(0, 100);
    y0_zero = 1'b0;

    // Rerun after a failing run: results cleared at the start edge
    push_sweep(); push_rand_5a(); push_res(0, 22, 0, 0, 1);
    kick(0);
    chk("err_cleared_at_start", 32'(err[0]), 32'd0);
    chk("ffi_cleared_at_start", 32'(ffi[0]), 32'd0);
    chk("done_cleared_at_start", 32'(done[0]), 32'd0);
    wait_run(0, 100);

    // Extra start pulse sampled at t0+5 must be ignored
    push_sweep(); push_rand_5a(); push_res(0, 22, 0, 0, 1);
    kick(0);
    repeat (5) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_run(0, 100);

    // Asynchronous reset mid-run at t0+9
    push_sweep();
    kick(0);
    repeat (9) @(posedge clk);
    #2;
    reset_b = 1'b0;
    #1;
    aborts[0]++;
    chk_zero("async_reset_outputs", 0);
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
    push_sweep(); push_rand_5a(); push_res(0, 22, 0, 0, 1);
    kick(0); wait_run(0, 100);

    // SETTLE=3 with y glitching on the non-sample cycles
    push_sweep(); push_rand_5a(); push_res(1, 44, 0, 0, 1);
    kick(1); wait_run(1, 200);

    // SEED=0 -> replaced by 8'h01, single random vector 001
    push_sweep(); q_vec.push_back(3'b001); push_res(2, 18, 0, 0, 1);
    kick(2); wait_run(2, 100);

    if (q_res.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL pending_results: %0d expected results never seen", q_res.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
